// File: rtl/fsl_m_arbiter.sv
// fsl_m_arbiter: packet-granular round-robin arbiter sharing one FSL master
// link among N_REQ requesters. All FSL outputs are registered.
// Optional build macro FSL_ARB_HDR_EN inserts a header word
// {seq[7:0], zeros, grant_id} ahead of every packet.
module fsl_m_arbiter #(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = 32,
    parameter int ID_W    = 3
) (
    input  logic                     gclk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*D_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     fsl_m_full,
    output logic                     fsl_m_write,
    output logic [D_WIDTH-1:0]       fsl_m_data,
    output logic                     fsl_m_control,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id
);

    // Requester vectors padded to the full ID_W index space so grant_id
    // can index them directly.
    localparam int NPAD = 1 << ID_W;

`ifdef FSL_ARB_HDR_EN
    typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                busy_q, busy_d;
    logic                fsl_m_write_q, fsl_m_write_d;
    logic                fsl_m_control_q, fsl_m_control_d;
    logic [D_WIDTH-1:0]  fsl_m_data_q, fsl_m_data_d;
`ifdef FSL_ARB_HDR_EN
    logic [7:0]          seq_q, seq_d;
    logic [D_WIDTH-1:0]  hdr_word;
`endif

    logic [NPAD-1:0]     valid_pad, last_pad;
    logic [D_WIDTH-1:0]  data_arr [NPAD];
    logic                arb_found;
    logic [ID_W-1:0]     arb_idx, cand;
    logic                xfer_go;

    // Spread packed requester inputs into index-addressable form.
    always_comb begin
        valid_pad = '0;
        last_pad  = '0;
        for (int i = 0; i < NPAD; i++) data_arr[i] = '0;
        for (int i = 0; i < N_REQ; i++) begin
            valid_pad[i] = req_valid[i];
            last_pad[i]  = req_last[i];
            data_arr[i]  = req_data[i*D_WIDTH +: D_WIDTH];
        end
    end

    // Round-robin pick: first valid requester after rr_ptr, wrapping at N_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!arb_found && valid_pad[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Word handshake with the granted requester; others always see ready=0.
    always_comb begin
        xfer_go   = (state_q == XFER) && valid_pad[grant_id_q] && !fsl_m_full;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++)
            if (xfer_go && (ID_W'(i) == grant_id_q)) req_ready[i] = 1'b1;
    end

`ifdef FSL_ARB_HDR_EN
    // Header word: sequence number on top, requester index at the bottom.
    always_comb begin
        hdr_word                  = '0;
        hdr_word[D_WIDTH-1 -: 8]  = seq_q;
        hdr_word[ID_W-1:0]        = grant_id_q;
    end
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_id_d      = grant_id_q;
        busy_d          = busy_q;
        fsl_m_write_d   = 1'b0;
        fsl_m_control_d = 1'b0;
        fsl_m_data_d    = fsl_m_data_q;
`ifdef FSL_ARB_HDR_EN
        seq_d           = seq_q;
`endif
        case (state_q)
            IDLE: begin
                // Arbitration cycle: no word moves.
                if (arb_found) begin
                    grant_id_d = arb_idx;
                    busy_d     = 1'b1;
`ifdef FSL_ARB_HDR_EN
                    state_d    = HDR;
`else
                    state_d    = XFER;
`endif
                end
            end
`ifdef FSL_ARB_HDR_EN
            HDR: begin
                if (!fsl_m_full) begin
                    fsl_m_write_d = 1'b1;
                    fsl_m_data_d  = hdr_word;
                    seq_d         = seq_q + 8'd1;
                    state_d       = XFER;
                end
            end
`endif
            XFER: begin
                // Grant is held until the last word, regardless of stalls.
                if (xfer_go) begin
                    fsl_m_write_d   = 1'b1;
                    fsl_m_data_d    = data_arr[grant_id_q];
                    fsl_m_control_d = last_pad[grant_id_q];
                    if (last_pad[grant_id_q]) begin
                        rr_ptr_d = grant_id_q;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset truncates any packet in flight.
    always_ff @(posedge gclk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            rr_ptr_q        <= ID_W'(N_REQ - 1);
            grant_id_q      <= '0;
            busy_q          <= 1'b0;
            fsl_m_write_q   <= 1'b0;
            fsl_m_control_q <= 1'b0;
            fsl_m_data_q    <= '0;
`ifdef FSL_ARB_HDR_EN
            seq_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_id_q      <= grant_id_d;
            busy_q          <= busy_d;
            fsl_m_write_q   <= fsl_m_write_d;
            fsl_m_control_q <= fsl_m_control_d;
            fsl_m_data_q    <= fsl_m_data_d;
`ifdef FSL_ARB_HDR_EN
            seq_q           <= seq_d;
`endif
        end
    end

    assign fsl_m_write   = fsl_m_write_q;
    assign fsl_m_control = fsl_m_control_q;
    assign fsl_m_data    = fsl_m_data_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_fsl_m_arbiter.sv
// Self-checking bench for fsl_m_arbiter: directed scenarios plus a random
// phase, all scored against a link-ownership reference model.
module tb_fsl_m_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 3;
`ifdef FSL_ARB_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic            gclk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0, req_last = '0, req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic            fsl_m_full = 1'b0;
    logic            fsl_m_write, fsl_m_control, busy;
    logic [DW-1:0]   fsl_m_data;
    logic [IW-1:0]   grant_id;

    fsl_m_arbiter #(.N_REQ(N), .D_WIDTH(DW), .ID_W(IW)) dut (
        .gclk(gclk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fsl_m_full(fsl_m_full),
        .fsl_m_write(fsl_m_write), .fsl_m_data(fsl_m_data),
        .fsl_m_control(fsl_m_control), .busy(busy), .grant_id(grant_id)
    );

    always #5 gclk = ~gclk;

    int checks = 0, errors = 0;

    // Stimulus: per-requester queues of {last, data}.
    logic [DW:0] q [N][$];
    bit          gate [N];
    bit          rnd_gate = 0, rnd_full = 0, full_dir = 0;

    // Observed DUT words: payload and header streams.
    logic [DW:0] log_q[$];
    logic [DW:0] hlog_q[$];

    // Reference model: who owns the link, rotation pointer, output regs.
    int          m_owner, m_rr, m_seq, m_gid;
    bit          m_hdr, m_busy, m_write, m_ctrl, m_is_hdr;
    logic [DW-1:0] m_data;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += q[i].size();
        return s;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_rr = N - 1; m_seq = 0; m_gid = 0;
        m_hdr = 0; m_busy = 0; m_write = 0; m_ctrl = 0; m_is_hdr = 0;
        m_data = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit g;
            g = rnd_gate ? ($urandom_range(0, 3) != 0) : gate[i];
            if (q[i].size() > 0) begin
                req_valid[i]          = g;
                req_data[i*DW +: DW]  = q[i][0][DW-1:0];
                req_last[i]           = q[i][0][DW];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
        fsl_m_full = rnd_full ? ($urandom_range(0, 3) == 0) : full_dir;
    endtask

    // One cycle of the link as described behaviourally: an idle link picks
    // the next valid requester in rotation; an owned link moves one word of
    // the owner's packet when the FIFO has room; the owner keeps the link
    // until its last word.
    task automatic model_step();
        logic [N-1:0] exp_rdy;
        int idx;
        exp_rdy  = '0;
        m_write  = 0;
        m_ctrl   = 0;
        m_is_hdr = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_rr + k) % N;
                if (m_owner < 0 && req_valid[idx]) begin
                    m_owner = idx; m_gid = idx; m_busy = 1; m_hdr = HDR_EN;
                end
            end
        end else if (m_hdr) begin
            if (!fsl_m_full) begin
                m_write = 1; m_is_hdr = 1;
                m_data = '0;
                m_data[DW-1 -: 8] = m_seq[7:0];
                m_data[IW-1:0] = m_gid[IW-1:0];
                m_seq = (m_seq + 1) % 256;
                m_hdr = 0;
            end
        end else if (req_valid[m_owner] && !fsl_m_full) begin
            exp_rdy[m_owner] = 1'b1;
            m_write = 1;
            m_data  = req_data[m_owner*DW +: DW];
            m_ctrl  = req_last[m_owner];
            void'(q[m_owner].pop_front());
            if (m_ctrl) begin m_rr = m_owner; m_owner = -1; m_busy = 0; end
        end
        chk("req_ready", req_ready, exp_rdy);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle();
        drive();
        #1;
        model_step();
        @(posedge gclk);
        #1;
        chk("fsl_m_write", fsl_m_write, m_write);
        chk("fsl_m_control", fsl_m_control, m_ctrl);
        chk("fsl_m_data", fsl_m_data, m_data);
        chk("busy", busy, m_busy);
        chk("grant_id", grant_id, m_gid);
        if (fsl_m_write) begin
            if (m_is_hdr) hlog_q.push_back({fsl_m_control, fsl_m_data});
            else          log_q.push_back({fsl_m_control, fsl_m_data});
        end
        @(negedge gclk);
    endtask

    // Asynchronous reset raised mid-cycle; outputs must clear immediately.
    task automatic reset_dut();
        #2 reset = 1'b1;
        #1;
        chk("rst_write", fsl_m_write, 0);
        chk("rst_data", fsl_m_data, 0);
        chk("rst_control", fsl_m_control, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        model_reset();
        for (int i = 0; i < N; i++) begin q[i].delete(); gate[i] = 0; end
        full_dir = 0;
        @(negedge gclk);
        reset = 1'b0;
    endtask

    task automatic run_until_empty(int budget);
        int c;
        c = 0;
        while (pending() > 0 && c < budget) begin cycle(); c++; end
        chk("drain_timeout", pending(), 0);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) gate[i] = 0;
        @(negedge gclk);
        reset_dut();

        // T1: single 3-word packet from requester 0.
        log_q.delete();
        q[0].push_back({1'b0, 32'hA0});
        q[0].push_back({1'b0, 32'hA1});
        q[0].push_back({1'b1, 32'hA2});
        gate[0] = 1;
        for (int c = 0; c < 7; c++) cycle();
        chk("t1_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_w0", log_q[0], {1'b0, 32'hA0});
            chk("t1_w1", log_q[1], {1'b0, 32'hA1});
            chk("t1_w2", log_q[2], {1'b1, 32'hA2});
        end
        chk("t1_busy", busy, 0);
        chk("t1_gid", grant_id, 0);

        // T2: all four requesters stream 1-word packets; rotation 0,1,2,3,...
        reset_dut();
        log_q.delete();
        for (int i = 0; i < N; i++) begin
            for (int n = 0; n < 3; n++) q[i].push_back({1'b1, 32'(i * 256 + n)});
            gate[i] = 1;
        end
        run_until_empty(100);
        chk("t2_count", log_q.size(), 12);
        for (int k = 0; k < 12 && k < log_q.size(); k++)
            chk("t2_order", log_q[k], {1'b1, 32'((k % 4) * 256 + k / 4)});

        // T3: requester 2 stalls mid-packet; requester 1 must not interleave.
        log_q.delete();
        for (int i = 0; i < N; i++) gate[i] = 0;
        for (int n = 0; n < 4; n++) q[2].push_back({n == 3, 32'hC0 + 32'(n)});
        q[1].push_back({1'b0, 32'hD0});
        q[1].push_back({1'b1, 32'hD1});
        gate[2] = 1;
        for (int c = 0; c < (HDR_EN ? 4 : 3); c++) cycle();
        gate[1] = 1; gate[2] = 0;
        for (int c = 0; c < 3; c++) cycle();
        gate[2] = 1;
        run_until_empty(40);
        chk("t3_count", log_q.size(), 6);
        if (log_q.size() == 6) begin
            for (int n = 0; n < 4; n++) chk("t3_c", log_q[n], {n == 3, 32'hC0 + 32'(n)});
            chk("t3_d0", log_q[4], {1'b0, 32'hD0});
            chk("t3_d1", log_q[5], {1'b1, 32'hD1});
        end

        // T4: FIFO full for 5 cycles mid-packet; no loss or duplication.
        log_q.delete();
        for (int i = 0; i < N; i++) gate[i] = 0;
        for (int n = 0; n < 6; n++) q[0].push_back({n == 5, 32'hE0 + 32'(n)});
        gate[0] = 1;
        for (int c = 0; c < (HDR_EN ? 4 : 3); c++) cycle();
        full_dir = 1;
        for (int c = 0; c < 5; c++) cycle();
        full_dir = 0;
        run_until_empty(40);
        chk("t4_count", log_q.size(), 6);
        for (int n = 0; n < 6 && n < log_q.size(); n++)
            chk("t4_order", log_q[n], {n == 5, 32'hE0 + 32'(n)});

        // T5: reset while word 2 of a 4-word packet is offered.
        log_q.delete();
        for (int i = 0; i < N; i++) gate[i] = 0;
        for (int n = 0; n < 4; n++) q[2].push_back({n == 3, 32'hF0 + 32'(n)});
        gate[2] = 1;
        for (int c = 0; c < (HDR_EN ? 3 : 2); c++) cycle();
        drive();
        reset_dut();
        chk("t5_truncated", log_q.size(), 1);
        log_q.delete();
        q[0].push_back({1'b1, 32'h50});
        q[1].push_back({1'b1, 32'h51});
        gate[0] = 1; gate[1] = 1;
        cycle();
        chk("t5_first_grant", grant_id, 0);
        run_until_empty(40);
        chk("t5_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t5_w0", log_q[0], {1'b1, 32'h50});
            chk("t5_w1", log_q[1], {1'b1, 32'h51});
        end

        // Random phase: random packets, valid gaps and FIFO backpressure.
        rnd_gate = 1; rnd_full = 1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int r, len;
                r   = $urandom_range(0, N - 1);
                len = $urandom_range(1, 5);
                if (q[r].size() < 12)
                    for (int j = 0; j < len; j++) q[r].push_back({j == len - 1, 32'($urandom())});
            end
            cycle();
        end
        rnd_full = 0;
        run_until_empty(800);
        rnd_gate = 0;

`ifdef FSL_ARB_HDR_EN
        // Header test: 258 single-word packets from requester 3.
        reset_dut();
        log_q.delete(); hlog_q.delete();
        for (int n = 0; n < 258; n++) q[3].push_back({1'b1, 32'h3000 + 32'(n)});
        gate[3] = 1;
        run_until_empty(1000);
        chk("hdr_count", hlog_q.size(), 258);
        chk("hdr_pkts", log_q.size(), 258);
        for (int k = 0; k < hlog_q.size(); k++)
            chk("hdr_word", hlog_q[k], {1'b0, 32'((k % 256) << 24) | 32'd3});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fsl_m_arbiter.md
Name: fsl_m_arbiter

Overview:
- Shares one FSL master link among N_REQ on-chip requesters (PCX-side packet sources, debug/dummy clients).
- Round-robin arbitration at packet granularity: a grant is held from the first word until the word flagged last.
- fsl_m_control is driven high on the final word of each packet, so downstream sees packet boundaries.
- Output stage is fully registered; sits directly in front of the FSL master FIFO.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- D_WIDTH, 32, FSL data width.
- ID_W, 3, width of the requester index; must satisfy 2^ID_W >= N_REQ.

Ports:
- gclk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester word valid.
- req_last  in  N_REQ  per-requester: current word ends the packet.
- req_data  in  N_REQ*D_WIDTH  packed words; requester i occupies bits [i*D_WIDTH +: D_WIDTH].
- req_ready  out  N_REQ  per-requester word accepted this cycle (combinational).
- fsl_m_full  in  1  FSL master FIFO full.
- fsl_m_write  out  1  registered FSL write strobe.
- fsl_m_data  out  D_WIDTH  registered FSL data.
- fsl_m_control  out  1  registered FSL control; 1 on the last word of a packet.
- busy  out  1  registered; 1 while a packet is in progress (state != IDLE).
- grant_id  out  ID_W  registered index of the current or last granted requester.

Behaviour:
- Reset, asynchronous and immediate: fsl_m_write=0, fsl_m_data=0, fsl_m_control=0, busy=0, grant_id=0, state=IDLE, rr_ptr=N_REQ-1. With these values requester 0 wins first.
- FSM states: IDLE, HDR (present only with the option compiled in), XFER.
- IDLE:
  - If any req_valid is high, grant the first valid requester searching from rr_ptr+1 upward, modulo N_REQ.
  - Latch grant_id; set busy=1; go to XFER, or to HDR when the option is compiled in.
  - No word is transferred in the arbitration cycle.
- XFER:
  - req_ready[g] = req_valid[g] & ~fsl_m_full, where g is the granted requester. All other req_ready bits are 0.
  - A transfer happens when req_ready[g]=1. On the next edge: fsl_m_write=1, fsl_m_data=req_data[g], fsl_m_control=req_last[g].
  - No transfer: fsl_m_write=0, fsl_m_control=0, fsl_m_data held.
- Latency: a word accepted at edge t appears on fsl_m_* during cycle t+1. At most one write per cycle.
- Transfer with req_last[g]=1: rr_ptr<=g; state<=IDLE; busy<=0 at that edge.
- Packet gap: minimum one IDLE cycle between packets. Maximum sustained rate is one word per cycle inside a packet.
- fsl_m_full is sampled combinationally every cycle. While it is high, no transfer occurs and the grant is held indefinitely.
- Granted requester dropping req_valid mid-packet: the grant is held and no other requester may interleave. Interleaving is never allowed.
- Single-word packets (req_last=1 on the first word) are legal.
- Simultaneous requests: only the round-robin winner is served. Losers keep req_valid asserted and are served in rotation order.
- Reset mid-packet: the packet is truncated (no control word is emitted); the FSM restarts in IDLE.
- Requesters must hold req_data/req_last stable while req_valid=1 and req_ready=0.

Optional Feature:
- Macro: FSL_ARB_HDR_EN.
- Defined:
  - The HDR state is inserted after arbitration.
  - When ~fsl_m_full, one header word is written: fsl_m_data = {seq[7:0], zeros, grant_id} with grant_id in bits [ID_W-1:0] and seq in bits [D_WIDTH-1:D_WIDTH-8]; fsl_m_control=0.
  - Then go to XFER.
  - seq is an 8-bit packet counter: reset to 0, incremented once per header, wraps from 255 to 0.
  - req_ready is 0 during HDR.
- Undefined: no HDR state, no seq counter; the FSM goes IDLE->XFER directly.

Test Plan:
- Reset, then req_valid=4'b0001 with a 3-word packet 0xA0,0xA1,0xA2 (last on 0xA2) and full=0 -> fsl_m_write high for 3 consecutive cycles starting 2 cycles after req_valid rises; control=1 only with 0xA2; busy returns to 0; grant_id=0.
- All four requesters each hold 1-word packets continuously -> service order 0,1,2,3,0,...; each write is followed by one idle cycle; grant_id tracks the order.
- Requester 2 in mid-packet while req 1 is valid; req 2 drops valid for 3 cycles -> no req 1 words appear until req 2's last word is written.
- fsl_m_full=1 for 5 cycles mid-packet -> fsl_m_write=0 and req_ready=0 for those cycles; no word is lost or duplicated; the sequence resumes in order.
- Assert reset during word 2 of a 4-word packet -> outputs are 0 within the same cycle; the next grant goes to requester 0.
- FSL_ARB_HDR_EN defined, 258 single-word packets from requester 3 -> each packet is preceded by a header with control=0 and low bits=3; seq runs 0..255, 0, 1.
